ifu_fetch_pipe: RTL and testbench
=================================

# ifu_fetch_pipe

Parametrised, decoupled instruction fetch unit for the pipelined core. It holds the word-addressed PC and selects the next PC from three prioritised redirect sources (register jump, jump, branch). It issues requests to instruction memory through a valid/ready handshake with variable-latency, in-order responses. Fetched instructions are buffered in a small queue and handed to decode with their PC and the sequential return addresses. In-flight responses are discarded after a redirect.

## Interface
- ADDR_W, 30: word-address width; byte addresses are ADDR_W+2 bits.
- RESET_PC, 0: word address loaded on reset.
- QDEPTH, 4: fetch-queue depth and credit limit; power of two, ≥2.
- INSTR_W, 32: instruction width.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- jr_valid, jmp_valid, br_valid  in  1 each  redirect requests.
- jr_target, jmp_target, br_target  in  ADDR_W each  redirect word addresses.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  ADDR_W+2  byte address; bits [1:0] are 2'b00.
- rsp_valid  in  1  response valid; always accepted.
- rsp_data  in  INSTR_W  instruction.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes.
- out_instr  out  INSTR_W  instruction.
- out_pc  out  ADDR_W+2  byte PC of out_instr.
- out_seq  out  ADDR_W+2  out_pc+4 (delay-slot / link address).
- out_seq2  out  ADDR_W+2  out_pc+8 (link past delay slot).

## Operation
- **State**
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next expected valid response.
  - infl: outstanding requests, 0..QDEPTH.
  - drop: responses still to discard, 0..QDEPTH.
  - FIFO occupancy occ.
- **Redirect priority:** jr > jmp > br. With any redirect valid, the selected target is loaded into both fetch_pc and rsp_pc, the FIFO is cleared, and drop <= infl minus (1 if a response arrives this cycle). That arriving response is discarded.
- **Request:** req_valid = rst && !redirect && (infl+occ < QDEPTH). On req_valid && req_ready: fetch_pc += 1 and infl += 1.
- **Response:** on rsp_valid, infl -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: {rsp_pc, rsp_data} is pushed into the FIFO and rsp_pc += 1.
- The credit rule guarantees the FIFO never overflows, so there is no rsp_ready.
- **Pop:** out_valid = occ > 0. A pop occurs on out_valid && out_ready. Simultaneous push and pop keeps occ unchanged.
- **Arithmetic:** all PC arithmetic wraps modulo 2^ADDR_W; out_seq and out_seq2 wrap the same way. FIFO pointers wrap modulo QDEPTH.
- A response with infl == 0 is a protocol violation and is flagged by an assertion.

## Timing
- **Reset values:** fetch_pc = rsp_pc = RESET_PC; infl = drop = occ = 0; req_valid = 0, out_valid = 0, req_addr = RESET_PC<<2, data outputs 0.
- **First request** is in the first cycle after rst deasserts.
- **Response to decode:** a response at edge N is visible on out_* after edge N (registered FIFO, no bypass). Minimum fetch-to-decode is request cycle + memory latency + 1.
- **Redirect:** in cycle N, req_valid is 0. The first request to the target is in cycle N+1, or later if credits are exhausted by to-be-dropped in-flight requests.
- **Back-pressure:** req_addr and req_valid stay stable while req_valid && !req_ready, unless a redirect occurs (the request is withdrawn).
- **Redirect in the same cycle as a pop:** the pop is ignored and the FIFO is emptied.
- **Reset mid-operation:** all state returns to reset values immediately. Later responses from memory are the environment's responsibility; memory is reset together with the unit.

## Structure
- Package ifu_pkg:
  - default ADDR_W, INSTR_W, RESET_PC;
  - redirect-select enum {SEL_SEQ, SEL_BR, SEL_JMP, SEL_JR};
  - function pc_to_byte(addr) returning {addr, 2'b00}.
- Sub-module ifu_fifo, parametrised by WIDTH and DEPTH:
  - push, pop and synchronous clear;
  - occ output;
  - async active-low reset.
- Top level: redirect priority mux, credit/drop counters, PC registers.

## Test plan
- Reset with RESET_PC=0x100, req_ready=1, 1-cycle memory, out_ready=1 -> req_addr 0x400, 0x404, 0x408…; out_pc 0x400 with out_seq 0x404 and out_seq2 0x408.
- out_ready=0 with QDEPTH=4 -> at most 4 requests issued, req_valid held 0, occ=4, no response lost. Release out_ready -> streaming resumes in order.
- 3 requests in flight, br_valid with br_target=0x40 -> 3 responses dropped; first out_pc is 0x100.
- jr_valid, jmp_valid and br_valid in the same cycle with distinct targets -> jr_target wins.
- fetch_pc = 2^ADDR_W-1 -> next req_addr is 0; out_seq of the last word wraps to 0.
- req_ready low for 5 cycles -> req_addr stable. Redirect during the stall -> req_valid 0 that cycle, new target next cycle.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned IFU_ADDR_W  = 30;
  localparam int unsigned IFU_INSTR_W = 32;
  localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 30'h0;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_JR  = 2'd3
  } redir_sel_e;

  function automatic logic [IFU_ADDR_W+1:0] pc_to_byte(input logic [IFU_ADDR_W-1:0] addr);
    return {addr, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_pipe_chk.sv
// Protocol checks for the fetch unit's memory response interface.
module ifu_fetch_pipe_chk #(
  parameter int unsigned CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             rsp_valid_i,
  input logic [CNT_W-1:0] infl_i,
  input logic [CNT_W-1:0] drop_i
);

  a_rsp_needs_request: assert property (@(posedge clk) disable iff (!rst)
    rsp_valid_i |-> (infl_i != {CNT_W{1'b0}}));

  a_drop_le_infl: assert property (@(posedge clk) disable iff (!rst)
    drop_i <= infl_i);

endmodule

// File: rtl/ifu_fifo.sv
// Small registered FIFO with synchronous clear; no bypass from push to output.
module ifu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             do_push_s, do_pop_s;

  assign do_push_s = push_i && !clr_i && (occ_q != CNT_W'(DEPTH));
  assign do_pop_s  = pop_i && !clr_i && (occ_q != {CNT_W{1'b0}});
  assign data_o    = mem_q[rd_ptr_q];
  assign occ_o     = occ_q;

  // Occupancy next state: simultaneous push and pop leave it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({do_push_s, do_pop_s})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {CNT_W{1'b0}};
    end else if (clr_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  // Storage array, zeroed on reset so the data outputs start at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ifu_fetch_pipe.sv
// Decoupled instruction fetch: redirect mux, credit-limited requests to memory,
// in-order responses buffered for decode; stale responses dropped after a redirect.
module ifu_fetch_pipe
  import ifu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(IFU_RESET_PC),
  parameter int unsigned          QDEPTH   = 4,
  parameter int unsigned          INSTR_W  = IFU_INSTR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jr_valid_i,
  input  logic [ADDR_W-1:0]   jr_target_i,
  input  logic                jmp_valid_i,
  input  logic [ADDR_W-1:0]   jmp_target_i,
  input  logic                br_valid_i,
  input  logic [ADDR_W-1:0]   br_target_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic [ADDR_W+1:0]   req_addr_o,
  input  logic                rsp_valid_i,
  input  logic [INSTR_W-1:0]  rsp_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [INSTR_W-1:0]  out_instr_o,
  output logic [ADDR_W+1:0]   out_pc_o,
  output logic [ADDR_W+1:0]   out_seq_o,
  output logic [ADDR_W+1:0]   out_seq2_o
);

  localparam int unsigned CNT_W = $clog2(QDEPTH+1);
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]   infl_q, infl_d, drop_q, drop_d, occ_s;
  redir_sel_e         sel_s;
  logic [ADDR_W-1:0]  tgt_s;
  logic               redirect_s, credit_s, req_fire_s, push_s, pop_s;
  logic [ENT_W-1:0]   fifo_out_s;
  logic [ADDR_W-1:0]  pc_w_s, seq_w_s, seq2_w_s;

  // Redirect priority: jr over jmp over br.
  always_comb begin
    sel_s = SEL_SEQ;
    tgt_s = fetch_pc_q;
    if (jr_valid_i) begin
      sel_s = SEL_JR;
      tgt_s = jr_target_i;
    end else if (jmp_valid_i) begin
      sel_s = SEL_JMP;
      tgt_s = jmp_target_i;
    end else if (br_valid_i) begin
      sel_s = SEL_BR;
      tgt_s = br_target_i;
    end else begin
      sel_s = SEL_SEQ;
      tgt_s = fetch_pc_q;
    end
  end

  assign redirect_s  = (sel_s != SEL_SEQ);
  assign credit_s    = ({1'b0, infl_q} + {1'b0, occ_s}) < (CNT_W+1)'(QDEPTH);
  assign req_valid_o = rst && !redirect_s && credit_s;
  assign req_fire_s  = req_valid_o && req_ready_i;
  assign push_s      = rsp_valid_i && !redirect_s && (drop_q == {CNT_W{1'b0}});
  assign out_valid_o = (occ_s != {CNT_W{1'b0}});
  assign pop_s       = out_valid_o && out_ready_i && !redirect_s;

  // Next-state for PCs and the in-flight / drop counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    infl_d     = infl_q;
    drop_d     = drop_q;
    case (sel_s)
      SEL_JR, SEL_JMP, SEL_BR: begin
        fetch_pc_d = tgt_s;
        rsp_pc_d   = tgt_s;
        infl_d     = infl_q - CNT_W'(rsp_valid_i);
        drop_d     = infl_q - CNT_W'(rsp_valid_i);
      end
      SEL_SEQ: begin
        if (req_fire_s) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        else            fetch_pc_d = fetch_pc_q;
        infl_d = infl_q + CNT_W'(req_fire_s) - CNT_W'(rsp_valid_i);
        if (rsp_valid_i && (drop_q != {CNT_W{1'b0}})) begin
          drop_d = drop_q - CNT_W'(1);
        end else if (push_s) begin
          rsp_pc_d = rsp_pc_q + ADDR_W'(1);
        end else begin
          drop_d = drop_q;
        end
      end
      default: begin
        fetch_pc_d = fetch_pc_q;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      infl_q     <= {CNT_W{1'b0}};
      drop_q     <= {CNT_W{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      infl_q     <= infl_d;
      drop_q     <= drop_d;
    end
  end

  ifu_fifo #(.WIDTH(ENT_W), .DEPTH(QDEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (redirect_s),
    .push_i (push_s),
    .pop_i  (pop_s),
    .data_i ({rsp_pc_q, rsp_data_i}),
    .data_o (fifo_out_s),
    .occ_o  (occ_s)
  );

  assign pc_w_s      = fifo_out_s[ENT_W-1:INSTR_W];
  assign seq_w_s     = pc_w_s + ADDR_W'(1);
  assign seq2_w_s    = pc_w_s + ADDR_W'(2);
  assign out_instr_o = fifo_out_s[INSTR_W-1:0];

  // The package helper is fixed at the default width; other widths format inline.
  if (ADDR_W == IFU_ADDR_W) begin : g_fmt_pkg
    assign req_addr_o = pc_to_byte(fetch_pc_q);
    assign out_pc_o   = pc_to_byte(pc_w_s);
    assign out_seq_o  = pc_to_byte(seq_w_s);
    assign out_seq2_o = pc_to_byte(seq2_w_s);
  end else begin : g_fmt_gen
    assign req_addr_o = {fetch_pc_q, 2'b00};
    assign out_pc_o   = {pc_w_s, 2'b00};
    assign out_seq_o  = {seq_w_s, 2'b00};
    assign out_seq2_o = {seq2_w_s, 2'b00};
  end

  ifu_fetch_pipe_chk #(.CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .rsp_valid_i (rsp_valid_i),
    .infl_i      (infl_q),
    .drop_i      (drop_q)
  );

endmodule

// File: tb/tb_ifu_fetch_pipe.sv
// Scoreboard bench for ifu_fetch_pipe: in-order memory model with variable latency,
// expected decode stream pushed on kept responses and compared on each pop.
module tb_ifu_fetch_pipe;

  typedef struct packed {
    logic [29:0] addr;
    logic        stale;
    logic [3:0]  wcnt;
  } mem_ent_t;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } sb_ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        jr_valid_i, jmp_valid_i, br_valid_i;
  logic [29:0] jr_target_i, jmp_target_i, br_target_i;
  logic        req_valid_o, req_ready_i;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_instr_o, out_pc_o, out_seq_o, out_seq2_o;

  mem_ent_t    mem_q[$];
  sb_ent_t     sb_q[$];
  logic [29:0] exp_fetch_pc;
  int          lat_min, lat_max;
  int          n_req;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  always #5 clk = ~clk;

  ifu_fetch_pipe #(
    .ADDR_W(30), .RESET_PC(30'h100), .QDEPTH(4), .INSTR_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jr_valid_i   (jr_valid_i),
    .jr_target_i  (jr_target_i),
    .jmp_valid_i  (jmp_valid_i),
    .jmp_target_i (jmp_target_i),
    .br_valid_i   (br_valid_i),
    .br_target_i  (br_target_i),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_addr_o   (req_addr_o),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_instr_o  (out_instr_o),
    .out_pc_o     (out_pc_o),
    .out_seq_o    (out_seq_o),
    .out_seq2_o   (out_seq2_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive the memory response, observe handshakes at the settled point,
  // update the model as of the coming edge, then age the memory queue.
  task automatic cycle();
    logic        rsp_now, redir;
    logic [29:0] tgt;
    logic [31:0] d;
    mem_ent_t    e;
    sb_ent_t     s;
    rsp_now = (mem_q.size() > 0) && (mem_q[0].wcnt == 4'd0);
    d = rsp_now ? data_of(mem_q[0].addr) : 32'h0;
    rsp_valid_i = rsp_now;
    rsp_data_i  = d;
    #1;
    redir = jr_valid_i | jmp_valid_i | br_valid_i;
    tgt = jr_valid_i ? jr_target_i : (jmp_valid_i ? jmp_target_i : br_target_i);
    check_eq("out_valid", 32'(out_valid_o), 32'(sb_q.size() != 0));
    if (out_valid_o && out_ready_i && !redir && sb_q.size() != 0) begin
      s = sb_q.pop_front();
      check_eq("out_instr", out_instr_o, s.instr);
      check_eq("out_pc",    out_pc_o,   {s.pc, 2'b00});
      check_eq("out_seq",   out_seq_o,  {s.pc + 30'd1, 2'b00});
      check_eq("out_seq2",  out_seq2_o, {s.pc + 30'd2, 2'b00});
    end
    if (rsp_now) begin
      e = mem_q.pop_front();
      if (!e.stale && !redir) sb_q.push_back({e.addr, d});
    end
    if (redir) begin
      check_eq("req_valid_redirect", 32'(req_valid_o), 32'd0);
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      sb_q.delete();
      exp_fetch_pc = tgt;
    end else if (req_valid_o && req_ready_i) begin
      check_eq("req_addr", req_addr_o, {exp_fetch_pc, 2'b00});
      e.addr  = exp_fetch_pc;
      e.stale = 1'b0;
      e.wcnt  = 4'($urandom_range(lat_max, lat_min));
      mem_q.push_back(e);
      exp_fetch_pc = exp_fetch_pc + 30'd1;
      n_req++;
    end
    @(posedge clk);
    foreach (mem_q[i]) if (mem_q[i].wcnt != 4'd0) mem_q[i].wcnt = mem_q[i].wcnt - 4'd1;
    @(negedge clk);
  endtask

  task automatic clear_redirects();
    jr_valid_i  = 1'b0;
    jmp_valid_i = 1'b0;
    br_valid_i  = 1'b0;
  endtask

  // Stop issuing and let memory and the queue empty, within a cycle budget.
  task automatic quiet();
    req_ready_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (mem_q.size() == 0 && sb_q.size() == 0) break;
      cycle();
    end
    cycle();
    check_eq("drain", 32'(mem_q.size() + sb_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    clear_redirects();
    jr_target_i = 30'h0; jmp_target_i = 30'h0; br_target_i = 30'h0;
    req_ready_i = 1'b0; out_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_data_i = 32'h0;
    exp_fetch_pc = 30'h100;
    lat_min = 1; lat_max = 1; n_req = 0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_valid", 32'(req_valid_o), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
    check_eq("rst_req_addr",  req_addr_o, 32'h400);
    check_eq("rst_out_instr", out_instr_o, 32'h0);
    check_eq("rst_out_pc",    out_pc_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    req_ready_i = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check_eq("first_req_valid", 32'(req_valid_o), 32'd1);
    repeat (20) cycle();

    // Decode stalled: credits cap requests at the queue depth.
    quiet();
    out_ready_i = 1'b0;
    req_ready_i = 1'b1;
    n_req = 0;
    repeat (15) cycle();
    check_eq("credit_req_count", 32'(n_req), 32'd4);
    #1;
    check_eq("credit_req_valid", 32'(req_valid_o), 32'd0);
    out_ready_i = 1'b1;
    lat_min = 1; lat_max = 3;
    repeat (30) cycle();

    // Three requests in flight, then a branch drops all of them.
    quiet();
    lat_min = 4; lat_max = 4;
    req_ready_i = 1'b1;
    n_req = 0;
    repeat (3) cycle();
    check_eq("inflight_count", 32'(n_req), 32'd3);
    br_valid_i = 1'b1; br_target_i = 30'h40;
    cycle();
    clear_redirects();
    for (int i = 0; i < 20 && !out_valid_o; i++) cycle();
    #1;
    check_eq("br_first_valid", 32'(out_valid_o), 32'd1);
    check_eq("br_first_pc", out_pc_o, 32'h100);
    repeat (10) cycle();

    // All three redirect sources at once.
    quiet();
    lat_min = 1; lat_max = 1;
    req_ready_i = 1'b1;
    jr_valid_i = 1'b1;  jr_target_i  = 30'h200;
    jmp_valid_i = 1'b1; jmp_target_i = 30'h300;
    br_valid_i = 1'b1;  br_target_i  = 30'h380;
    cycle();
    clear_redirects();
    #1;
    check_eq("prio_jr_addr", req_addr_o, 32'h800);
    repeat (10) cycle();

    // Address wrap at the top of the word space.
    quiet();
    req_ready_i = 1'b1;
    out_ready_i = 1'b0;
    jr_valid_i = 1'b1; jr_target_i = 30'h3FFF_FFFF;
    cycle();
    clear_redirects();
    #1;
    check_eq("wrap_addr_top", req_addr_o, 32'hFFFF_FFFC);
    cycle();
    #1;
    check_eq("wrap_addr_zero", req_addr_o, 32'h0);
    for (int i = 0; i < 10 && !out_valid_o; i++) cycle();
    #1;
    check_eq("wrap_out_pc",   out_pc_o,   32'hFFFF_FFFC);
    check_eq("wrap_out_seq",  out_seq_o,  32'h0);
    check_eq("wrap_out_seq2", out_seq2_o, 32'h4);
    out_ready_i = 1'b1;
    repeat (10) cycle();

    // Memory back-pressure holds the request; a redirect withdraws it.
    lat_min = 1; lat_max = 2;
    repeat (5) cycle();
    req_ready_i = 1'b0;
    cycle();
    repeat (5) begin
      cycle();
      #1;
      check_eq("stall_valid", 32'(req_valid_o), 32'd1);
      check_eq("stall_addr",  req_addr_o, {exp_fetch_pc, 2'b00});
    end
    jmp_valid_i = 1'b1; jmp_target_i = 30'h1234;
    cycle();
    clear_redirects();
    #1;
    check_eq("stall_redir_addr", req_addr_o, 32'h48D0);
    req_ready_i = 1'b1;
    repeat (10) cycle();

    // Random traffic with occasional redirects.
    lat_min = 1; lat_max = 4;
    repeat (300) begin
      req_ready_i = ($urandom_range(99, 0) < 70);
      out_ready_i = ($urandom_range(99, 0) < 70);
      jr_valid_i  = ($urandom_range(99, 0) < 2);
      jmp_valid_i = ($urandom_range(99, 0) < 2);
      br_valid_i  = ($urandom_range(99, 0) < 3);
      jr_target_i  = 30'($urandom());
      jmp_target_i = 30'($urandom());
      br_target_i  = 30'($urandom());
      cycle();
    end
    clear_redirects();
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
